// File: rtl/apb_rambus_bridge.sv
// APB3 slave to RamBus master bridge: registered chip-select handshake with ack timeout,
// misaligned-address rejection and a saturating error counter.
module apb_rambus_bridge #(
  parameter int unsigned       ADDR_W         = 14,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [ADDR_W-1:0] RamBusAddress,
  output logic [DATA_W-1:0] RamBusDataIn,
  output logic              RamBusnCs,
  output logic              RamBusWrnRd,
  output logic              RamBusLatch,
  input  logic [DATA_W-1:0] RamBusDataOut,
  input  logic              RamBusAck,
  output logic [7:0]        ErrCount
);

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned ERR_CNT_W = 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;
  localparam logic [1:0] RECOVER = 2'd3;

  localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX      = '1;

  logic [1:0]           state, stateNext;
  logic [CNT_W-1:0]     cnt, cntNext;
  logic                 errFlag, errFlagNext;
  logic [DATA_W-1:0]    prdataNext;
  logic                 preadyNext, pslverrNext;
  logic [ADDR_W-1:0]    addrNext;
  logic [DATA_W-1:0]    dataInNext;
  logic                 nCsNext, wrnRdNext, latchNext;
  logic [ERR_CNT_W-1:0] errCountNext;
  logic                 errCountInc;

  // Next-state and next-output logic; PREADY is raised on the edge that enters RESP.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    errFlagNext  = errFlag;
    prdataNext   = PRDATA;
    preadyNext   = 1'b0;
    pslverrNext  = 1'b0;
    addrNext     = RamBusAddress;
    dataInNext   = RamBusDataIn;
    nCsNext      = RamBusnCs;
    wrnRdNext    = RamBusWrnRd;
    latchNext    = RamBusLatch;
    errCountInc  = 1'b0;
    errCountNext = ErrCount;

    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          addrNext   = PADDR;
          dataInNext = PWDATA;
          wrnRdNext  = PWRITE;
          if (PADDR[1:0] != 2'b00) begin
            stateNext   = RESP;
            errFlagNext = 1'b1;
            preadyNext  = 1'b1;
            pslverrNext = 1'b1;
            prdataNext  = ERR_DATA;
            errCountInc = 1'b1;
          end else begin
            stateNext   = ACCESS;
            errFlagNext = 1'b0;
            nCsNext     = 1'b0;
            latchNext   = 1'b1;
            cntNext     = '0;
          end
        end
      end
      ACCESS: begin
        cntNext = cnt + CNT_W'(1);
        if (!PSEL) begin
          // Master abandoned the transfer: release the bus and count it as an error.
          stateNext   = RECOVER;
          nCsNext     = 1'b1;
          latchNext   = 1'b0;
          errCountInc = 1'b1;
        end else if (RamBusAck) begin
          stateNext   = RESP;
          nCsNext     = 1'b1;
          latchNext   = 1'b0;
          errFlagNext = 1'b0;
          if (!RamBusWrnRd) prdataNext = RamBusDataOut;
          preadyNext  = PENABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          stateNext   = RESP;
          nCsNext     = 1'b1;
          latchNext   = 1'b0;
          errFlagNext = 1'b1;
          if (PENABLE) begin
            preadyNext  = 1'b1;
            pslverrNext = 1'b1;
            prdataNext  = ERR_DATA;
            errCountInc = 1'b1;
          end
        end
      end
      RESP: begin
        if (PREADY) begin
          stateNext = RECOVER;
        end else if (PENABLE) begin
          preadyNext  = 1'b1;
          pslverrNext = errFlag;
          if (errFlag) begin
            prdataNext  = ERR_DATA;
            errCountInc = 1'b1;
          end
        end
      end
      RECOVER: begin
        // Wait for the previous ack to drop so it cannot complete the next access.
        if (!RamBusAck) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    if (errCountInc && (ErrCount != ERR_MAX)) errCountNext = ErrCount + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state         <= IDLE;
      cnt           <= '0;
      errFlag       <= 1'b0;
      PRDATA        <= '0;
      PREADY        <= 1'b0;
      PSLVERR       <= 1'b0;
      RamBusAddress <= '0;
      RamBusDataIn  <= '0;
      RamBusnCs     <= 1'b1;
      RamBusWrnRd   <= 1'b0;
      RamBusLatch   <= 1'b0;
      ErrCount      <= '0;
    end else begin
      state         <= stateNext;
      cnt           <= cntNext;
      errFlag       <= errFlagNext;
      PRDATA        <= prdataNext;
      PREADY        <= preadyNext;
      PSLVERR       <= pslverrNext;
      RamBusAddress <= addrNext;
      RamBusDataIn  <= dataInNext;
      RamBusnCs     <= nCsNext;
      RamBusWrnRd   <= wrnRdNext;
      RamBusLatch   <= latchNext;
      ErrCount      <= errCountNext;
    end
  end

endmodule

// File: tb/tb_apb_rambus_bridge.sv
// Bench for apb_rambus_bridge: directed vector table, randomized transfers against a
// transaction-level model, and hand-written corner sequences.
module tb_apb_rambus_bridge;

  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 8;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              nRst;
  logic              PSEL, PENABLE, PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA, PRDATA;
  logic              PREADY, PSLVERR;
  logic [ADDR_W-1:0] RamBusAddress;
  logic [DATA_W-1:0] RamBusDataIn, RamBusDataOut;
  logic              RamBusnCs, RamBusWrnRd, RamBusLatch, RamBusAck;
  logic [7:0]        ErrCount;

  apb_rambus_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT), .ERR_DATA(ERR_DATA)
  ) dut (
    .clk(clk), .nRst(nRst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .RamBusAddress(RamBusAddress), .RamBusDataIn(RamBusDataIn), .RamBusnCs(RamBusnCs),
    .RamBusWrnRd(RamBusWrnRd), .RamBusLatch(RamBusLatch), .RamBusDataOut(RamBusDataOut),
    .RamBusAck(RamBusAck), .ErrCount(ErrCount)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatch = 0;

  // Transaction-level model state
  int          modelErr;
  logic [31:0] modelPrdata;

  // Observed results of the last transfer
  int          rSetupWait, rReadyAt, rNcsLow, rLatchHi;
  logic        rErr, rReadyAfter, rErrAfter, rWrnRd;
  logic [31:0] rPrdata, rDataIn;
  logic [13:0] rAddr;
  logic [7:0]  rErrCount;

  typedef struct {
    logic        write;
    logic [13:0] addr;
    logic [31:0] wdata;
    int          ackDelay;
    logic [31:0] rdata;
    logic        expErr;
    logic [31:0] expPrdata;
    int          expNcsLow;
    int          expErrCount;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected outcome from the transfer rules: alignment, ack delay versus timeout.
  task automatic predict(input logic write, input logic [13:0] addr, input int ackDelay,
                         input logic [31:0] rdata, output logic expErr,
                         output logic [31:0] expPrd, output int expNcs);
    if (addr[1:0] != 2'b00) begin
      expErr = 1'b1; expNcs = 0;
    end else if (ackDelay < int'(TIMEOUT)) begin
      expErr = 1'b0; expNcs = ackDelay + 1;
    end else begin
      expErr = 1'b1; expNcs = int'(TIMEOUT);
    end
    if (expErr) modelPrdata = ERR_DATA;
    else if (!write) modelPrdata = rdata;
    if (expErr && modelErr < 255) modelErr++;
    expPrd = modelPrdata;
  endtask

  // One APB transfer with a RamBus responder acking ackDelay cycles into ACCESS.
  task automatic doTransfer(input logic write, input logic [13:0] addr, input logic [31:0] wdata,
                            input int ackDelay, input logic [31:0] rdata,
                            input int holdBefore, input bit keepAck);
    int c;
    int idx;
    int k;
    bit captured;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = write; PADDR = addr; PWDATA = wdata;
    RamBusDataOut = rdata;
    captured = 1'b0; c = 0;
    rReadyAt = -1; rNcsLow = 0; rLatchHi = 0; rReadyAfter = 1'b1; rErrAfter = 1'b1;
    while (!captured && c < 64) begin
      if (c >= holdBefore) RamBusAck = 1'b0;
      @(posedge clk); #1;
      c++;
      captured = !RamBusnCs || PREADY;
    end
    rSetupWait = c;
    rAddr = RamBusAddress; rDataIn = RamBusDataIn; rWrnRd = RamBusWrnRd;
    if (captured) begin
      PENABLE = 1'b1;
      k = 0; idx = 0;
      while (idx < 64) begin
        if (!RamBusnCs) rNcsLow++;
        if (RamBusLatch) rLatchHi++;
        if (PREADY) begin
          rReadyAt = idx; rErr = PSLVERR; rPrdata = PRDATA; rErrCount = ErrCount;
          break;
        end
        if (!RamBusnCs) begin
          RamBusAck = (k >= ackDelay);
          k++;
        end else if (!keepAck) begin
          RamBusAck = 1'b0;
        end
        @(posedge clk); #1;
        idx++;
      end
      if (rReadyAt >= 0) begin
        @(posedge clk); #1;
        rReadyAfter = PREADY; rErrAfter = PSLVERR;
      end
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    if (!keepAck) RamBusAck = 1'b0;
  endtask

  task automatic checkResult(input string tag, input logic write, input logic [13:0] addr,
                             input logic [31:0] wdata, input logic expErr,
                             input logic [31:0] expPrd, input int expNcs, input int expErrCnt);
    int expReadyAt;
    expReadyAt = (addr[1:0] != 2'b00) ? 0 : expNcs;
    check({tag, " readyAt"},    64'(rReadyAt),    64'(expReadyAt));
    check({tag, " pslverr"},    64'(rErr),        64'(expErr));
    check({tag, " prdata"},     64'(rPrdata),     64'(expPrd));
    check({tag, " nCsLow"},     64'(rNcsLow),     64'(expNcs));
    check({tag, " latchHi"},    64'(rLatchHi),    64'(expNcs));
    check({tag, " readyPulse"}, 64'({rReadyAfter, rErrAfter}), 64'(0));
    check({tag, " addr"},       64'(rAddr),       64'(addr));
    check({tag, " wrnrd"},      64'(rWrnRd),      64'(write));
    check({tag, " dataIn"},     64'(rDataIn),     64'(wdata));
    check({tag, " errCount"},   64'(rErrCount),   64'(expErrCnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic        eErr;
    logic [31:0] ePrd;
    int          eNcs;
    logic        w;
    logic [13:0] a;
    logic [31:0] wd, rd;
    int          dly;
    bit          readySeen;

    vecs[0] = '{1'b0, 14'h0040, 32'h0,        0,   32'h12345678, 1'b0, 32'h12345678, 1, 0};
    vecs[1] = '{1'b1, 14'h0104, 32'hA5A5A5A5, 4,   32'h0,        1'b0, 32'h12345678, 5, 0};
    vecs[2] = '{1'b0, 14'h0200, 32'h0,        100, 32'h11111111, 1'b1, 32'hDEADBEEF, 8, 1};
    vecs[3] = '{1'b0, 14'h0042, 32'h0,        0,   32'h22222222, 1'b1, 32'hDEADBEEF, 0, 2};
    vecs[4] = '{1'b0, 14'h0008, 32'h0,        7,   32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 8, 2};
    vecs[5] = '{1'b1, 14'h3FFC, 32'h87654321, 0,   32'h33333333, 1'b0, 32'hCAFEF00D, 1, 2};
    vecs[6] = '{1'b1, 14'h0001, 32'h44444444, 0,   32'h0,        1'b1, 32'hDEADBEEF, 0, 3};

    nRst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    RamBusDataOut = '0; RamBusAck = 1'b0;
    modelErr = 0; modelPrdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset data", {PRDATA, RamBusDataIn}, 64'(0));
    check("reset ctrl", 64'({PREADY, PSLVERR, RamBusAddress, RamBusnCs, RamBusWrnRd, RamBusLatch, ErrCount}),
          64'({1'b0, 1'b0, 14'h0, 1'b1, 1'b0, 1'b0, 8'h0}));
    @(negedge clk); nRst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      predict(vecs[i].write, vecs[i].addr, vecs[i].ackDelay, vecs[i].rdata, eErr, ePrd, eNcs);
      doTransfer(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].ackDelay, vecs[i].rdata, 0, 1'b0);
      checkResult($sformatf("vec%0d", i), vecs[i].write, vecs[i].addr, vecs[i].wdata,
                  vecs[i].expErr, vecs[i].expPrdata, vecs[i].expNcsLow, vecs[i].expErrCount);
    end

    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 14'($urandom);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      dly = int'($urandom_range(0, 10));
      wd = $urandom; rd = $urandom;
      predict(w, a, dly, rd, eErr, ePrd, eNcs);
      doTransfer(w, a, wd, dly, rd, 0, 1'b0);
      checkResult($sformatf("rnd%0d", i), w, a, wd, eErr, ePrd, eNcs, modelErr);
    end

    // Ack held high after a response delays the next queued read until it drops.
    predict(1'b0, 14'h0010, 0, 32'h0BADF00D, eErr, ePrd, eNcs);
    doTransfer(1'b0, 14'h0010, 32'h0, 0, 32'h0BADF00D, 0, 1'b1);
    checkResult("hold1", 1'b0, 14'h0010, 32'h0, eErr, ePrd, eNcs, modelErr);
    predict(1'b0, 14'h0020, 0, 32'h600DCAFE, eErr, ePrd, eNcs);
    doTransfer(1'b0, 14'h0020, 32'h0, 0, 32'h600DCAFE, 4, 1'b0);
    check("hold2 setupWait", 64'(rSetupWait), 64'(6));
    checkResult("hold2", 1'b0, 14'h0020, 32'h0, eErr, ePrd, eNcs, modelErr);

    // PSEL dropped in ACCESS: bus released, no PREADY, error counted.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 14'h0300; RamBusAck = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (!RamBusnCs) break;
    end
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1;
    if (modelErr < 255) modelErr++;
    check("pseldrop bus", 64'({RamBusnCs, RamBusLatch}), 64'(2'b10));
    check("pseldrop errCount", 64'(ErrCount), 64'(modelErr));
    readySeen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (PREADY || PSLVERR) readySeen = 1'b1;
      @(posedge clk); #1;
    end
    check("pseldrop noReady", 64'(readySeen), 64'(0));

    // Asynchronous reset in the middle of ACCESS.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 14'h1234; PWDATA = 32'h5A5A1234;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (!RamBusnCs) break;
    end
    PENABLE = 1'b1;
    @(posedge clk); #3;
    nRst = 1'b0;
    #1;
    check("midreset data", {PRDATA, RamBusDataIn}, 64'(0));
    check("midreset ctrl", 64'({PREADY, PSLVERR, RamBusAddress, RamBusnCs, RamBusWrnRd, RamBusLatch, ErrCount}),
          64'({1'b0, 1'b0, 14'h0, 1'b1, 1'b0, 1'b0, 8'h0}));
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk); nRst = 1'b1;
    @(posedge clk); #1;
    modelErr = 0; modelPrdata = '0;

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      predict(1'b0, 14'h0003, 0, 32'h0, eErr, ePrd, eNcs);
      doTransfer(1'b0, 14'h0003, 32'h0, 0, 32'h0, 0, 1'b0);
      if (i == 99)  check("sat errCount100", 64'(ErrCount), 64'(modelErr));
      if (i == 299) check("sat errCount300", 64'(ErrCount), 64'(modelErr));
    end
    check("sat final", 64'(ErrCount), 64'(255));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
